// File: rtl/seg_pkg.sv
// seg_pkg: glyph table, command codes and helpers shared by the segment display controller
package seg_pkg;

    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;

    localparam logic [6:0] CODE_BLANK = 7'h10;
    localparam logic [6:0] CODE_DASH  = 7'h11;
    localparam logic [6:0] CODE_CLEAR = 7'h7F;

    typedef enum logic [1:0] {
        CMD_GLYPH,
        CMD_CLEAR,
        CMD_BAD
    } cmd_kind_t;

    typedef struct packed {
        cmd_kind_t  kind;
        logic [6:0] glyph;
    } cmd_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Segment order is {g,f,e,d,c,b,a}, active high
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Undefined codes still shift in a blank digit, flagged as bad
    function automatic cmd_t decode(input logic [6:0] c);
        cmd_t d;
        d.kind  = CMD_GLYPH;
        d.glyph = GLYPH_BLANK;
        if (c[6:4] == 3'b000) d.glyph = hex_glyph(c[3:0]);
        else if (c == CODE_DASH) d.glyph = GLYPH_DASH;
        else if (c == CODE_CLEAR) d.kind = CMD_CLEAR;
        else if (c != CODE_BLANK) d.kind = CMD_BAD;
        return d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty and show-ahead read data
module sync_fifo
    import seg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             nRESET,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt, cnt_nx;
    logic             do_wr, do_rd;

    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign cnt_nx  = cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage array, no reset needed since pointers define validity
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally at the power-of-two depth; flags follow the next count
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= do_wr ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_rd ? rd_ptr + 1'b1 : rd_ptr;
            cnt    <= cnt_nx;
            full   <= cnt_nx == DEPTH_C;
            empty  <= cnt_nx == '0;
        end
    end

endmodule

// File: rtl/multi_digit_seg_ctrl.sv
// multi_digit_seg_ctrl: buffers receiver command bytes and drives a multiplexed common-anode display
module multi_digit_seg_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DEPTH       = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int SCROLL_DIV  = 5000000,
    parameter bit BIT_REV     = 1
) (
    input  logic              clk,
    input  logic              nRESET,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              scroll_en,
    input  logic              clr_ovf,
    output logic [6:0]        seg_n,
    output logic [DIGITS-1:0] an_n,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow,
    output logic              bad_code
);

    localparam int IW = (DIGITS > 1) ? clog2(DIGITS) : 1;
    localparam int RW = clog2(REFRESH_DIV);
    localparam int SW = clog2(SCROLL_DIV);
    localparam int DW = DIGITS * 7;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SCR_LAST = SW'(SCROLL_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [7:0]                rev_byte;
    logic [6:0]                code_in, fifo_dout, code_q;
    logic                      code_v, pop_req, pop, scroll_wrap, ref_wrap;
    logic [SW-1:0]             scroll_cnt;
    logic [RW-1:0]             ref_cnt;
    logic [IW-1:0]             idx, idx_nx;
    logic [DIGITS-1:0][6:0]    disp;
    cmd_t                      dec;

    assign rev_byte = rev8(rx_data);
    assign code_in  = BIT_REV ? rev_byte[6:0] : rx_data[6:0];
    assign rx_ready = ~fifo_full;

    sync_fifo #(
        .WIDTH(7),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .nRESET (nRESET),
        .wr_en  (rx_valid),
        .wr_data(code_in),
        .rd_en  (pop_req),
        .rd_data(fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Pop pacing, scan stepping and decode of the staged code
    always_comb begin
        scroll_wrap = scroll_cnt == SCR_LAST;
        pop_req     = scroll_en ? scroll_wrap : 1'b1;
        pop         = pop_req & ~fifo_empty;
        ref_wrap    = ref_cnt == REF_LAST;
        idx_nx      = ref_wrap ? ((idx == IDX_LAST) ? '0 : idx + 1'b1) : idx;
        dec         = decode(code_q);
    end

    // Scroll timer only runs in scroll mode and restarts whenever the mode is left
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) scroll_cnt <= '0;
        else scroll_cnt <= (!scroll_en || scroll_wrap) ? '0 : scroll_cnt + 1'b1;
    end

    // Popped byte is staged one cycle before it reaches the display register
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            code_v <= 1'b0;
            code_q <= '0;
        end else begin
            code_v <= pop;
            code_q <= pop ? fifo_dout : code_q;
        end
    end

    // Newest glyph enters digit 0 and older digits move left; CLEAR blanks everything
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) disp <= {DIGITS{GLYPH_BLANK}};
        else if (code_v) disp <= (dec.kind == CMD_CLEAR) ? {DIGITS{GLYPH_BLANK}} : (disp << 7) | DW'(dec.glyph);
    end

    // Sticky flags; a new event in the same cycle beats the clear
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            overflow <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            overflow <= (rx_valid & fifo_full) | (overflow & ~clr_ovf);
            bad_code <= (code_v & (dec.kind == CMD_BAD)) | (bad_code & ~clr_ovf);
        end
    end

    // Anode and segment outputs are both registered from the next index so they switch together
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            ref_cnt <= '0;
            idx     <= '0;
            an_n    <= ~DIGITS'(1);
            seg_n   <= 7'h7F;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
            idx     <= idx_nx;
            an_n    <= ~(DIGITS'(1) << idx_nx);
            seg_n   <= ~disp[idx_nx];
        end
    end

endmodule

// File: tb/tb_multi_digit_seg_ctrl.sv
// tb_multi_digit_seg_ctrl: directed vector bench for the multiplexed segment controller
module tb_multi_digit_seg_ctrl;

    typedef struct {
        logic [7:0] code;
        logic [6:0] glyph;
        logic       bad;
    } vec_t;

    localparam logic [6:0] G [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk = 1'b0;
    logic       nRESET = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       scroll_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       rx_ready, fifo_full, fifo_empty, overflow, bad_code;
    logic [6:0] seg_n;
    logic [3:0] an_n;

    int n_cmp = 0;
    int n_bad = 0;

    multi_digit_seg_ctrl #(
        .DIGITS     (4),
        .DEPTH      (8),
        .REFRESH_DIV(4),
        .SCROLL_DIV (16),
        .BIT_REV    (1)
    ) dut (
        .clk       (clk),
        .nRESET    (nRESET),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .scroll_en (scroll_en),
        .clr_ovf   (clr_ovf),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .overflow  (overflow),
        .bad_code  (bad_code)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic int idx_of(input logic [3:0] a);
        logic [3:0] m;
        for (int k = 0; k < 4; k++) begin
            m = 4'b0001 << k;
            if (a == ~m) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        rx_data  = rev(c);
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_digit(input int k, input logic [6:0] glyph, input string name);
        logic [6:0] want;
        bit found;
        found = 0;
        want = ~glyph;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (idx_of(an_n) == k) found = 1;
        end
        if (found) chk(name, seg_n, want);
        else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: digit %0d never scanned, an_n=%b", name, k, an_n);
        end
    endtask

    task automatic check_disp(input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                              input logic [6:0] d3, input string name);
        check_digit(0, d0, {name, "_d0"});
        check_digit(1, d1, {name, "_d1"});
        check_digit(2, d2, {name, "_d2"});
        check_digit(3, d3, {name, "_d3"});
    endtask

    vec_t       tv [8];
    logic [6:0] m [4];
    logic [6:0] want;
    logic [3:0] prev;
    int         run, changes, ix;

    initial begin
        tv[0] = '{8'h00, 7'h3F, 1'b0};
        tv[1] = '{8'h0F, 7'h71, 1'b0};
        tv[2] = '{8'h10, 7'h00, 1'b0};
        tv[3] = '{8'h11, 7'h40, 1'b0};
        tv[4] = '{8'h91, 7'h40, 1'b0};
        tv[5] = '{8'h55, 7'h00, 1'b1};
        tv[6] = '{8'h8A, 7'h77, 1'b0};
        tv[7] = '{8'h7E, 7'h00, 1'b1};

        // Reset state while held in reset
        #2 nRESET = 1'b0;
        #1;
        chk("rst_seg_n", seg_n, 7'h7F);
        chk("rst_an_n", an_n, 4'b1110);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_bad_code", bad_code, 0);
        repeat (2) @(negedge clk);
        nRESET = 1'b1;

        // Scroll mode: 10 back-to-back bytes, 8 fit, one pop every 16 clocks
        for (int k = 0; k < 4; k++) m[k] = 7'h00;
        scroll_en = 1'b1;
        rx_data   = rev(8'h01);
        rx_valid  = 1'b1;
        for (int e = 1; e <= 130; e++) begin
            @(negedge clk);
            if (e >= 18 && (e - 2) % 16 == 0 && (e - 2) / 16 <= 8) begin
                m[3] = m[2];
                m[2] = m[1];
                m[1] = m[0];
                m[0] = G[(e - 2) / 16];
            end
            ix = idx_of(an_n);
            if (ix < 0) chk("scroll_an_onehot", an_n, 4'b1110);
            else begin
                want = ~m[ix];
                chk("scroll_seg", seg_n, want);
            end
            if (e == 7)   chk("scroll_ready_e7", rx_ready, 1);
            if (e == 8)   chk("scroll_ready_e8", rx_ready, 0);
            if (e == 8)   chk("scroll_ovf_e8", overflow, 0);
            if (e == 9)   chk("scroll_ovf_e9", overflow, 1);
            if (e == 15)  chk("scroll_ready_e15", rx_ready, 0);
            if (e == 16)  chk("scroll_ready_e16", rx_ready, 1);
            if (e == 127) chk("scroll_empty_e127", fifo_empty, 0);
            if (e == 128) chk("scroll_empty_e128", fifo_empty, 1);
            if (e == 130) chk("scroll_ovf_sticky", overflow, 1);
            if (e <= 9) rx_data = rev(8'(e + 1));
            else rx_valid = 1'b0;
        end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("clr_ovf", overflow, 0);
        scroll_en = 1'b0;

        // Append mode "1234"
        for (int j = 1; j <= 4; j++) begin
            rx_data  = rev(8'(j));
            rx_valid = 1'b1;
            @(negedge clk);
            chk("append_empty_busy", fifo_empty, 0);
        end
        rx_valid = 1'b0;
        @(negedge clk);
        chk("append_empty_done", fifo_empty, 1);
        check_disp(G[4], G[3], G[2], G[1], "append_1234");
        chk("append_seg4", G[4], 7'h66);

        // CLEAR after "1234"
        send(8'h7F);
        repeat (3) @(negedge clk);
        chk("clear_bad", bad_code, 0);
        check_disp(7'h00, 7'h00, 7'h00, 7'h00, "clear");

        // Decode table in append mode
        for (int i = 0; i < 8; i++) begin
            send(tv[i].code);
            repeat (3) @(negedge clk);
            chk($sformatf("tv%0d_bad", i), bad_code, tv[i].bad);
            check_digit(0, tv[i].glyph, $sformatf("tv%0d_glyph", i));
            clr_ovf = 1'b1;
            @(negedge clk);
            clr_ovf = 1'b0;
            chk($sformatf("tv%0d_bad_clr", i), bad_code, 0);
        end
        check_disp(7'h00, 7'h77, 7'h00, 7'h40, "tv_history");

        // Scan order and slot length
        prev    = an_n;
        run     = 0;
        changes = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            run++;
            if (an_n !== prev) begin
                chk("scan_order", an_n, {prev[2:0], prev[3]});
                if (changes > 0) chk("scan_period", run, 4);
                changes++;
                run  = 0;
                prev = an_n;
            end
        end
        chk("scan_changes", changes >= 9, 1);

        // Overflow event in the same cycle as clr_ovf keeps the flag set
        scroll_en = 1'b1;
        for (int j = 0; j < 9; j++) begin
            rx_data  = rev(8'(j));
            rx_valid = 1'b1;
            clr_ovf  = (j == 8);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        clr_ovf  = 1'b0;
        chk("ovf_event_wins", overflow, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_clr2", overflow, 0);

        // Async reset mid-scroll with 5 entries queued
        repeat (39) @(negedge clk);
        chk("pre_rst_empty", fifo_empty, 0);
        chk("pre_rst_full", fifo_full, 0);
        #2 nRESET = 1'b0;
        #1;
        chk("mid_rst_empty", fifo_empty, 1);
        chk("mid_rst_ready", rx_ready, 1);
        chk("mid_rst_an_n", an_n, 4'b1110);
        chk("mid_rst_seg_n", seg_n, 7'h7F);
        @(negedge clk);
        nRESET = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("post_rst_empty", fifo_empty, 1);
            chk("post_rst_seg_n", seg_n, 7'h7F);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
